line_mem_responder: RTL and testbench
=====================================

Name: line_mem_responder

Overview:
- Memory-side endpoint for the cache refill/writeback interface: accepts line-burst requests from a cache and serves them from an internal word-addressed store.
- Read bursts return one word per beat; write bursts absorb one masked word per beat.
- Used as the backing memory below the cache in simulation and small FPGA builds.
- Fixed, programmable access latency precedes every burst.

Parameters:
WIDTH, 32, data/address width in bits; must be 32.
LINE_BYTES, 512, burst size in bytes; BEATS = LINE_BYTES*8/WIDTH = 128.
DEPTH_WORDS, 65536, store depth in WIDTH-bit words; power of two, multiple of BEATS.
LATENCY, 4, idle cycles between request acceptance and the first beat; 0 is legal.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, synchronous, active-high.
req_valid  in  1  request present; must stay high for the whole burst.
req_addr  in  WIDTH  byte address; low log2(LINE_BYTES) bits ignored (line-aligned base).
req_data  in  WIDTH  write data for the current beat.
req_mask  in  WIDTH/8  byte enables; nonzero at request start = write burst, zero = read burst.
resp_valid  out  1  beat handshake: read data valid / write beat accepted.
resp_data  out  WIDTH  read data for the current beat.
busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset: state IDLE, resp_valid 0, resp_data 0, busy 0, beat counter 0. Store contents are not cleared; they are undefined until written.
- Reset mid-burst aborts immediately and commits no further writes.
- States: IDLE, WAIT, BURST, DONE.
- IDLE, req_valid=1 in cycle T:
  - latch base word index = (req_addr >> 2) with the low log2(BEATS) bits cleared, modulo DEPTH_WORDS (higher address bits alias);
  - latch dir = |req_mask;
  - load latency counter; go WAIT (LATENCY>0) or BURST (LATENCY=0).
- WAIT: count down LATENCY cycles; BURST is entered at cycle T+1+LATENCY.
- BURST:
  - resp_valid = (state==BURST) && req_valid, combinational.
  - Beat k is accepted iff resp_valid=1; the beat counter advances only on acceptance.
  - Read: while resp_valid=1, resp_data = store[base+k] in the same cycle. resp_data is registered and prefetched, so there are no bubbles. With req_valid held, beat k appears at cycle T+1+LATENCY+k.
  - Write: on an accepted beat, store[base+k] byte i <= req_data byte i for each req_mask[i]=1. A per-beat mask of 0 writes nothing but still consumes the beat. The write is visible to any later burst.
  - After beat BEATS-1 is accepted, go DONE.
- DONE: one turnaround cycle, resp_valid 0, req_valid ignored; then IDLE.
  - If req_valid is still high in IDLE, a new burst starts (back-to-back bursts are legal).
- Abort: req_valid=0 in WAIT or BURST -> no beat accepted that cycle, next state IDLE. Already-accepted write beats stay committed; the remaining words are unchanged.
- dir is fixed for the whole burst; req_mask changes during BURST affect only byte enables of write beats.
- resp_data holds its last value when resp_valid=0, except that it is prefetched before the first read beat.
- busy=1 in WAIT, BURST, DONE.

Test Plan:
1. Reset check: assert rst 2 cycles, then req_valid=0 -> resp_valid=0, resp_data=0x0, busy=0 every cycle.
2. Write then read, LATENCY=4:
   - Write burst at 0x0000_0200, mask 4'hF, data 0x1000+k, req_valid held -> resp_valid high exactly cycles T+5..T+132, busy low at T+134.
   - Read burst at 0x0000_0200 -> resp_data = 0x1000+k at T'+5+k for k=0..127.
3. Alignment and aliasing:
   - Read at 0x0000_0234 -> same 128 words as base 0x200.
   - Read at 0x0004_0200 (DEPTH_WORDS=65536) -> aliases 0x200, returns 0x1000+k.
4. Partial mask: over 0x1000 at word 0x80, write burst whose beat 0 has mask 4'b0011 and data 0xAAAA_BBBB, remaining beats mask 0 -> read beat 0 = 0x0000_BBBB, beat 1 unchanged.
5. Abort: write burst data 0x5500+k into previously-zero line; drop req_valid in the cycle of beat 10 -> resp_valid=0 that cycle, IDLE next cycle; readback words 0..9 = 0x5500+k, words 10..127 = 0.
6. LATENCY=0, back-to-back:
   - Hold req_valid continuously -> first beat at T+1, DONE gap of one cycle, next burst accepted at the following IDLE cycle.
   - Mid-burst rst -> resp_valid=0 in the next cycle, no further words written.

Source files
------------

// File: rtl/line_mem_responder.sv
// line_mem_responder: memory-side endpoint that serves cache line bursts
// (one word per beat) from an internal word-addressed store after a fixed latency.
module line_mem_responder #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned LINE_BYTES  = 512,
  parameter int unsigned DEPTH_WORDS = 65536,
  parameter int unsigned LATENCY     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [WIDTH-1:0]   req_addr,
  input  logic [WIDTH-1:0]   req_data,
  input  logic [WIDTH/8-1:0] req_mask,
  output logic               resp_valid,
  output logic [WIDTH-1:0]   resp_data,
  output logic               busy
);

  localparam int unsigned NBYTES = WIDTH / 8;
  localparam int unsigned BOFS   = $clog2(NBYTES);
  localparam int unsigned BEATS  = LINE_BYTES * 8 / WIDTH;
  localparam int unsigned BW     = $clog2(BEATS);
  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam int unsigned LNW    = AW - BW;
  localparam int unsigned LW     = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam int unsigned RWW    = WIDTH - BOFS;

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    lat_q, lat_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic [LNW-1:0]   line_q, line_d;
  logic             dir_q, dir_d;      // 1 = write burst
  logic             rd_en_c;
  logic [AW-1:0]    rd_addr_c;
  logic             wr_en_c;
  logic [AW-1:0]    wr_addr_c;
  logic [RWW-1:0]   req_word;
  logic [LNW-1:0]   req_line;
  logic             unused_addr_bits;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  // Line index of the request; higher address bits alias, low bits select byte/beat.
  assign req_word         = req_addr[WIDTH-1:BOFS];
  assign req_line         = req_word[AW-1:BW];
  assign unused_addr_bits = ^{req_addr[BOFS-1:0], req_word};

  assign resp_valid = (state_q == BURST) && req_valid;
  assign busy       = (state_q != IDLE);
  assign wr_addr_c  = {line_q, beat_q};

  // State and burst-context registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lat_q   <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      dir_q   <= dir_d;
    end
  end

  // Next state, beat sequencing and store read/write strobes.
  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    beat_d    = beat_q;
    line_d    = line_q;
    dir_d     = dir_q;
    rd_en_c   = 1'b0;
    rd_addr_c = {line_q, beat_q};
    wr_en_c   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          line_d = req_line;
          dir_d  = |req_mask;
          lat_d  = LW'(LATENCY);
          beat_d = '0;
          if (LATENCY == 0) begin
            state_d   = BURST;
            rd_en_c   = ~|req_mask;
            rd_addr_c = {req_line, BW'(0)};
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else if (lat_q == LW'(1)) begin
          // Prefetch beat 0 so it is on resp_data the first BURST cycle.
          state_d   = BURST;
          rd_en_c   = ~dir_q;
          rd_addr_c = {line_q, BW'(0)};
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      BURST: begin
        if (!req_valid) begin
          state_d = IDLE;
        end else begin
          wr_en_c = dir_q;
          if (beat_q == BW'(BEATS - 1)) begin
            state_d = DONE;
          end else begin
            beat_d    = beat_q + BW'(1);
            rd_en_c   = ~dir_q;
            rd_addr_c = {line_q, beat_q + BW'(1)};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Byte-masked store write; a reset cycle commits nothing.
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (req_mask[i]) begin
          mem[wr_addr_c][8*i +: 8] <= req_data[8*i +: 8];
        end
      end
    end
  end

  // Registered read port, loaded one cycle ahead of each read beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_data <= '0;
    end else if (rd_en_c) begin
      resp_data <= mem[rd_addr_c];
    end
  end

endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: a LATENCY=4 and a LATENCY=0 instance driven
// with line bursts and compared against a word-level store model.
`timescale 1ns/1ps
module tb_line_mem_responder;

  localparam int BEATS = 128;
  localparam int NOBS  = 300;
  localparam int DEPTH = 65536;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;            // 0: LATENCY=4 instance, 1: LATENCY=0 instance
  logic        drv_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [3:0]  req_mask;
  logic        req_valid4, req_valid0;
  logic        resp_valid4, resp_valid0, busy4, busy0;
  logic [31:0] resp_data4, resp_data0;
  logic        mon_valid, mon_busy;
  logic [31:0] mon_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [int];
  logic [31:0] wdata [BEATS];
  logic [3:0]  wmask [BEATS];
  logic        obs_valid [NOBS];
  logic        obs_busy  [NOBS];
  logic [31:0] obs_data  [NOBS];

  always #5 clk = ~clk;

  assign req_valid4 = drv_valid & ~sel;
  assign req_valid0 = drv_valid & sel;
  assign mon_valid  = sel ? resp_valid0 : resp_valid4;
  assign mon_busy   = sel ? busy0 : busy4;
  assign mon_data   = sel ? resp_data0 : resp_data4;

  line_mem_responder #(.LATENCY(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid4), .req_addr(req_addr),
    .req_data(req_data), .req_mask(req_mask), .resp_valid(resp_valid4),
    .resp_data(resp_data4), .busy(busy4)
  );

  line_mem_responder #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_addr(req_addr),
    .req_data(req_data), .req_mask(req_mask), .resp_valid(resp_valid0),
    .resp_data(resp_data0), .busy(busy0)
  );

  function automatic int line_base(input logic [31:0] addr);
    return ((int'(addr >> 2) / BEATS) * BEATS) % DEPTH;
  endfunction

  function automatic int key(input logic s, input int word);
    return (s ? DEPTH : 0) + word;
  endfunction

  // Model keeps only words whose every byte is known.
  function automatic void model_write(input logic s, input int word,
                                      input logic [31:0] d, input logic [3:0] m);
    int          kk;
    logic [31:0] cur;
    kk = key(s, word);
    if (m == 4'hF) begin
      model[kk] = d;
    end else if (model.exists(kk)) begin
      cur = model[kk];
      for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
      model[kk] = cur;
    end
  endfunction

  // One burst with req_valid held (optionally dropped at beat abort_beat);
  // records outputs per cycle, cycle 0 being the request cycle.
  task automatic run_burst(input logic s, input logic [31:0] addr, input bit wr,
                           input int abort_beat);
    int lat, nc, base, k;
    lat  = s ? 0 : 4;
    nc   = lat + BEATS + 3;
    base = line_base(addr);
    sel  = s;
    for (int c = 0; c < nc; c++) begin
      @(posedge clk); #1;
      k        = c - 1 - lat;
      req_data = $urandom;
      req_mask = 4'($urandom);
      req_addr = $urandom;
      if (c == 0) begin
        drv_valid = 1'b1;
        req_addr  = addr;
        req_mask  = wr ? 4'hF : 4'h0;
      end else if (c <= lat) begin
        drv_valid = 1'b1;
      end else if (k < BEATS && (abort_beat < 0 || k < abort_beat)) begin
        drv_valid = 1'b1;
        if (wr) begin
          req_data = wdata[k];
          req_mask = wmask[k];
          model_write(s, base + k, wdata[k], wmask[k]);
        end
      end else begin
        drv_valid = 1'b0;
      end
      @(negedge clk);
      obs_valid[c] = mon_valid;
      obs_busy[c]  = mon_busy;
      obs_data[c]  = mon_data;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; drv_valid = 1'b0; sel = 1'b0;
    req_addr = '0; req_data = '0; req_mask = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({resp_valid4, resp_valid0} !== 2'b00) begin
        n_fail++; $display("FAIL reset_valid c=%0d got=%b exp=00", c, {resp_valid4, resp_valid0});
      end
      n_checks++;
      if ({busy4, busy0} !== 2'b00) begin
        n_fail++; $display("FAIL reset_busy c=%0d got=%b exp=00", c, {busy4, busy0});
      end
      n_checks++;
      if (resp_data4 !== 32'h0 || resp_data0 !== 32'h0) begin
        n_fail++; $display("FAIL reset_data c=%0d got=%h/%h exp=0", c, resp_data4, resp_data0);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_write_read();
    logic        exp_v, exp_b;
    logic [31:0] exp_d;
    for (int k = 0; k < BEATS; k++) begin wdata[k] = 32'h1000 + 32'(k); wmask[k] = 4'hF; end
    run_burst(1'b0, 32'h0000_0200, 1'b1, -1);
    for (int c = 0; c < 4 + BEATS + 3; c++) begin
      exp_v = (c >= 5 && c <= 132);
      exp_b = (c >= 1 && c <= 133);
      n_checks++;
      if (obs_valid[c] !== exp_v) begin
        n_fail++; $display("FAIL wr_valid c=%0d got=%b exp=%b", c, obs_valid[c], exp_v);
      end
      n_checks++;
      if (obs_busy[c] !== exp_b) begin
        n_fail++; $display("FAIL wr_busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_b);
      end
    end
    run_burst(1'b0, 32'h0000_0200, 1'b0, -1);
    for (int c = 0; c < 4 + BEATS + 3; c++) begin
      exp_v = (c >= 5 && c <= 132);
      n_checks++;
      if (obs_valid[c] !== exp_v) begin
        n_fail++; $display("FAIL rd_valid c=%0d got=%b exp=%b", c, obs_valid[c], exp_v);
      end
    end
    for (int k = 0; k < BEATS; k++) begin
      exp_d = 32'h1000 + 32'(k);
      n_checks++;
      if (obs_data[5 + k] !== exp_d) begin
        n_fail++; $display("FAIL rd_data k=%0d got=%h exp=%h", k, obs_data[5 + k], exp_d);
      end
    end
  endtask

  task automatic test_alignment();
    logic [31:0] addrs [2];
    logic [31:0] exp_d;
    addrs[0] = 32'h0000_0234;
    addrs[1] = 32'h0004_0200;
    for (int a = 0; a < 2; a++) begin
      run_burst(1'b0, addrs[a], 1'b0, -1);
      for (int k = 0; k < BEATS; k++) begin
        exp_d = 32'h1000 + 32'(k);
        n_checks++;
        if (obs_data[5 + k] !== exp_d) begin
          n_fail++;
          $display("FAIL align addr=%h k=%0d got=%h exp=%h", addrs[a], k, obs_data[5 + k], exp_d);
        end
      end
    end
  endtask

  task automatic test_partial_mask();
    for (int k = 0; k < BEATS; k++) begin wdata[k] = $urandom; wmask[k] = 4'h0; end
    wdata[0] = 32'hAAAA_BBBB;
    wmask[0] = 4'b0011;
    run_burst(1'b0, 32'h0000_0200, 1'b1, -1);
    run_burst(1'b0, 32'h0000_0200, 1'b0, -1);
    n_checks++;
    if (obs_data[5] !== 32'h0000_BBBB) begin
      n_fail++; $display("FAIL pmask_beat0 got=%h exp=0000bbbb", obs_data[5]);
    end
    n_checks++;
    if (obs_data[6] !== 32'h0000_1001) begin
      n_fail++; $display("FAIL pmask_beat1 got=%h exp=00001001", obs_data[6]);
    end
    for (int k = 2; k < BEATS; k++) begin
      n_checks++;
      if (obs_data[5 + k] !== model[key(1'b0, 'h80 + k)]) begin
        n_fail++;
        $display("FAIL pmask_rest k=%0d got=%h exp=%h", k, obs_data[5 + k], model[key(1'b0, 'h80 + k)]);
      end
    end
  endtask

  task automatic test_abort();
    logic [31:0] exp_d;
    for (int k = 0; k < BEATS; k++) begin wdata[k] = 32'h0; wmask[k] = 4'hF; end
    run_burst(1'b0, 32'h0000_0400, 1'b1, -1);
    for (int k = 0; k < BEATS; k++) wdata[k] = 32'h5500 + 32'(k);
    run_burst(1'b0, 32'h0000_0400, 1'b1, 10);
    n_checks++;
    if (obs_valid[14] !== 1'b1) begin
      n_fail++; $display("FAIL abort_beat9_valid got=%b exp=1", obs_valid[14]);
    end
    n_checks++;
    if (obs_valid[15] !== 1'b0) begin
      n_fail++; $display("FAIL abort_beat10_valid got=%b exp=0", obs_valid[15]);
    end
    n_checks++;
    if (obs_busy[16] !== 1'b0) begin
      n_fail++; $display("FAIL abort_idle_busy got=%b exp=0", obs_busy[16]);
    end
    run_burst(1'b0, 32'h0000_0400, 1'b0, -1);
    for (int k = 0; k < BEATS; k++) begin
      exp_d = (k < 10) ? 32'h5500 + 32'(k) : 32'h0;
      n_checks++;
      if (obs_data[5 + k] !== exp_d) begin
        n_fail++; $display("FAIL abort_data k=%0d got=%h exp=%h", k, obs_data[5 + k], exp_d);
      end
    end
  endtask

  task automatic test_latency0();
    for (int k = 0; k < BEATS; k++) begin wdata[k] = $urandom; wmask[k] = 4'hF; end
    run_burst(1'b1, 32'h0000_0800, 1'b1, -1);
    n_checks++;
    if (obs_valid[0] !== 1'b0 || obs_valid[1] !== 1'b1) begin
      n_fail++; $display("FAIL lat0_first got=%b%b exp=01", obs_valid[0], obs_valid[1]);
    end
    n_checks++;
    if (obs_valid[128] !== 1'b1 || obs_valid[129] !== 1'b0) begin
      n_fail++; $display("FAIL lat0_last got=%b%b exp=10", obs_valid[128], obs_valid[129]);
    end
    n_checks++;
    if (obs_busy[129] !== 1'b1 || obs_busy[130] !== 1'b0) begin
      n_fail++; $display("FAIL lat0_done_busy got=%b%b exp=10", obs_busy[129], obs_busy[130]);
    end
    for (int k = 0; k < BEATS; k++) wdata[k] = $urandom;
    run_burst(1'b1, 32'h0000_0A00, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    logic        exp_v, exp_b;
    int          kk;
    sel = 1'b1;
    for (int c = 0; c < 261; c++) begin
      @(posedge clk); #1;
      drv_valid = (c <= 258);
      req_addr  = (c < 130) ? 32'h0000_0800 : 32'h0000_0A00;
      req_mask  = (c == 0 || c == 130) ? 4'h0 : 4'($urandom);
      req_data  = $urandom;
      @(negedge clk);
      obs_valid[c] = mon_valid;
      obs_busy[c]  = mon_busy;
      obs_data[c]  = mon_data;
    end
    for (int c = 0; c < 261; c++) begin
      exp_v = (c >= 1 && c <= 128) || (c >= 131 && c <= 258);
      exp_b = (c >= 1 && c <= 129) || (c >= 131 && c <= 259);
      n_checks++;
      if (obs_valid[c] !== exp_v) begin
        n_fail++; $display("FAIL b2b_valid c=%0d got=%b exp=%b", c, obs_valid[c], exp_v);
      end
      n_checks++;
      if (obs_busy[c] !== exp_b) begin
        n_fail++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, obs_busy[c], exp_b);
      end
      if (exp_v) begin
        kk = (c <= 128) ? key(1'b1, 'h200 + c - 1) : key(1'b1, 'h280 + c - 131);
        n_checks++;
        if (obs_data[c] !== model[kk]) begin
          n_fail++; $display("FAIL b2b_data c=%0d got=%h exp=%h", c, obs_data[c], model[kk]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int k;
    for (int i = 0; i < BEATS; i++) wdata[i] = $urandom;
    sel = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      k         = c - 1;
      rst       = (c == 21);
      drv_valid = (c <= 22);
      req_addr  = 32'h0000_0800;
      req_mask  = (c == 22) ? 4'h0 : 4'hF;
      req_data  = (k >= 0 && k < BEATS) ? wdata[k] : 32'h0;
      if (k >= 0 && k < 20) model_write(1'b1, 'h200 + k, wdata[k], 4'hF);
      @(negedge clk);
      if (c == 22) begin
        n_checks++;
        if (resp_valid0 !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_valid got=%b exp=0", resp_valid0);
        end
        n_checks++;
        if (busy0 !== 1'b0) begin
          n_fail++; $display("FAIL rstmid_busy got=%b exp=0", busy0);
        end
        n_checks++;
        if (resp_data0 !== 32'h0) begin
          n_fail++; $display("FAIL rstmid_data got=%h exp=0", resp_data0);
        end
      end
    end
    run_burst(1'b1, 32'h0000_0800, 1'b0, -1);
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (obs_data[1 + i] !== model[key(1'b1, 'h200 + i)]) begin
        n_fail++;
        $display("FAIL rstmid_store k=%0d got=%h exp=%h", i, obs_data[1 + i], model[key(1'b1, 'h200 + i)]);
      end
    end
  endtask

  task automatic test_random();
    logic        s;
    logic [31:0] addr;
    int          lat, base, kk;
    for (int it = 0; it < 4; it++) begin
      s    = (it % 2 == 1);
      addr = $urandom;
      lat  = s ? 0 : 4;
      base = line_base(addr);
      for (int k = 0; k < BEATS; k++) begin wdata[k] = $urandom; wmask[k] = 4'hF; end
      run_burst(s, addr, 1'b1, -1);
      for (int k = 0; k < BEATS; k++) begin wdata[k] = $urandom; wmask[k] = 4'($urandom); end
      run_burst(s, addr, 1'b1, -1);
      run_burst(s, addr, 1'b0, -1);
      for (int k = 0; k < BEATS; k++) begin
        kk = key(s, base + k);
        n_checks++;
        if (obs_data[1 + lat + k] !== model[kk]) begin
          n_fail++;
          $display("FAIL rand_data it=%0d k=%0d got=%h exp=%h", it, k, obs_data[1 + lat + k], model[kk]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alignment();
    test_partial_mask();
    test_abort();
    test_latency0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
